// File: rtl/scpu_fetch_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : scpu_fetch_unit_if
//  Brief    : Instruction-memory request/ready port of the fetch stage.
//  Revision : 1.0
// ============================================================================
interface scpu_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_ready
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_ready
    );
endinterface
`default_nettype wire

// File: rtl/scpu_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : scpu_fetch_unit
//  Brief    : PC register, handshaked instruction fetch with timeout/retry and
//             next-PC selection for the single-cycle control unit.
//  Revision : 1.0
// ============================================================================
module scpu_fetch_unit #(
    parameter logic [31:0] RESET_PC      = 32'h0000_0000,
    parameter int unsigned FETCH_TIMEOUT = 16
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    scpu_fetch_unit_if.master       imem,
    input  wire logic [1:0]         Branch,
    input  wire logic [31:0]        jr_target,
    input  wire logic               exec_stall,
    output logic      [31:0]        inst,
    output logic      [5:0]         OPcode,
    output logic      [5:0]         Fun,
    output logic                    inst_valid,
    output logic      [31:0]        pc_out,
    output logic      [31:0]        pc_plus4,
    output logic                    fetch_err,
    output logic                    jr_misalign,
    output logic      [31:0]        retired
);

    localparam int CNT_W = (FETCH_TIMEOUT > 1) ? $clog2(FETCH_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] c_to_last  = CNT_W'(FETCH_TIMEOUT - 1);
    localparam logic [31:0]      c_reset_pc = {RESET_PC[31:2], 2'b00};

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_RETRY = 2'd2
    } state_t;

    state_t           r_state;
    logic [31:0]      r_pc;
    logic [31:0]      r_inst;
    logic [31:0]      r_retired;
    logic [CNT_W-1:0] r_cnt;
    logic             r_req;
    logic             r_valid;
    logic             r_ferr;
    logic             r_jmis;

    logic [31:0]      w_pc_plus4;
    logic [31:0]      w_br_off;
    logic [31:0]      w_next_pc;
    logic             w_jr_mis;

    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_br_off   = {{14{r_inst[15]}}, r_inst[15:0], 2'b00};
    assign w_jr_mis   = (Branch == 2'b11) && (jr_target[1:0] != 2'b00);

    always_comb begin
        w_next_pc = w_pc_plus4;
        case (Branch)
            2'b00:   w_next_pc = w_pc_plus4;
            2'b01:   w_next_pc = w_pc_plus4 + w_br_off;
            2'b10:   w_next_pc = {w_pc_plus4[31:28], r_inst[25:0], 2'b00};
            default: w_next_pc = {jr_target[31:2], 2'b00};
        endcase
    end

    // The request is registered, so the first fetch after reset spends one
    // cycle raising imem_req before the timeout counter starts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_FETCH;
            r_pc      <= c_reset_pc;
            r_inst    <= 32'd0;
            r_retired <= 32'd0;
            r_cnt     <= '0;
            r_req     <= 1'b0;
            r_valid   <= 1'b0;
            r_ferr    <= 1'b0;
            r_jmis    <= 1'b0;
        end else begin
            r_ferr <= 1'b0;
            r_jmis <= 1'b0;
            case (r_state)
                S_FETCH: begin
                    if (!r_req) begin
                        r_req <= 1'b1;
                    end else if (imem.imem_ready) begin
                        r_inst  <= imem.imem_rdata;
                        r_req   <= 1'b0;
                        r_valid <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= S_EXEC;
                    end else if (r_cnt == c_to_last) begin
                        r_ferr  <= 1'b1;
                        r_req   <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= S_RETRY;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RETRY: begin
                    r_req   <= 1'b1;
                    r_state <= S_FETCH;
                end
                S_EXEC: begin
                    if (!exec_stall) begin
                        r_pc      <= w_next_pc;
                        r_retired <= r_retired + 32'd1;
                        r_jmis    <= w_jr_mis;
                        r_valid   <= 1'b0;
                        r_req     <= 1'b1;
                        r_state   <= S_FETCH;
                    end
                end
                default: begin
                    r_req   <= 1'b0;
                    r_valid <= 1'b0;
                    r_cnt   <= '0;
                    r_state <= S_FETCH;
                end
            endcase
        end
    end

    assign imem.imem_req  = r_req;
    assign imem.imem_addr = r_pc;

    assign inst        = r_inst;
    assign OPcode      = r_inst[31:26];
    assign Fun         = r_inst[5:0];
    assign inst_valid  = r_valid;
    assign pc_out      = r_pc;
    assign pc_plus4    = w_pc_plus4;
    assign fetch_err   = r_ferr;
    assign jr_misalign = r_jmis;
    assign retired     = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_scpu_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_scpu_fetch_unit
//  Brief    : Self-checking bench for scpu_fetch_unit (vectors + random model).
//  Revision : 1.0
// ============================================================================
module tb_scpu_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        rst_n;
    logic [1:0]  branch;
    logic [31:0] jr_target;
    logic        exec_stall;
    logic [31:0] inst;
    logic [5:0]  opcode;
    logic [5:0]  fun;
    logic        inst_valid;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic        fetch_err;
    logic        jr_misalign;
    logic [31:0] retired;

    scpu_fetch_unit_if bus();

    scpu_fetch_unit #(
        .RESET_PC      (RESET_PC),
        .FETCH_TIMEOUT (16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem        (bus),
        .Branch      (branch),
        .jr_target   (jr_target),
        .exec_stall  (exec_stall),
        .inst        (inst),
        .OPcode      (opcode),
        .Fun         (fun),
        .inst_valid  (inst_valid),
        .pc_out      (pc_out),
        .pc_plus4    (pc_plus4),
        .fetch_err   (fetch_err),
        .jr_misalign (jr_misalign),
        .retired     (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] m_pc;
    logic [31:0] m_retired;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] iw;
        logic [1:0]  br;
        logic [31:0] jr;
        logic [31:0] exp_next;
        logic        exp_mis;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Next PC from the architectural rules, using plain integer arithmetic.
    function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] iw,
                                               input logic [1:0] br, input logic [31:0] jr);
        logic [31:0] seq;
        int          off;
        seq = pc + 32'd4;
        case (br)
            2'd0: return seq;
            2'd1: begin
                off = int'($signed(iw[15:0]));
                return seq + 32'(off * 4);
            end
            2'd2: return (seq & 32'hF000_0000) | ((iw & 32'h03FF_FFFF) << 2);
            default: return jr & 32'hFFFF_FFFC;
        endcase
    endfunction

    // One instruction: wait for request, answer after `delay` cycles, stall, retire.
    task automatic do_instr(input logic [31:0] iw, input logic [1:0] br, input logic [31:0] jr,
                            input int stall, input int delay,
                            output logic [31:0] o_addr, output logic o_mis);
        int w;
        o_addr = 32'd0;
        o_mis  = 1'b0;
        bus.imem_ready = 1'b0;
        exec_stall     = 1'b0;
        w = 0;
        while (!bus.imem_req && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!bus.imem_req) begin
            chk("req_wait", 32'd0, 32'd1);
            return;
        end
        chk("fetch_addr", bus.imem_addr, m_pc);
        for (int i = 0; i < delay; i++) begin
            bus.imem_ready = 1'b0;
            branch = 2'($urandom);
            @(negedge clk);
            chk("req_held", {31'd0, bus.imem_req}, 32'd1);
        end
        bus.imem_ready = 1'b1;
        bus.imem_rdata = iw;
        @(negedge clk);
        bus.imem_ready = 1'($urandom);
        bus.imem_rdata = $urandom;
        chk("exec_valid", {31'd0, inst_valid}, 32'd1);
        chk("exec_inst", inst, iw);
        chk("exec_opcode", {26'd0, opcode}, {26'd0, iw[31:26]});
        chk("exec_fun", {26'd0, fun}, {26'd0, iw[5:0]});
        chk("exec_pc", pc_out, m_pc);
        chk("exec_pc4", pc_plus4, m_pc + 32'd4);
        chk("exec_req_low", {31'd0, bus.imem_req}, 32'd0);
        chk("exec_no_ferr", {31'd0, fetch_err}, 32'd0);
        chk("exec_no_jmis", {31'd0, jr_misalign}, 32'd0);
        for (int i = 0; i < stall; i++) begin
            exec_stall = 1'b1;
            branch     = 2'($urandom);
            jr_target  = $urandom;
            @(negedge clk);
            bus.imem_ready = 1'($urandom);
            bus.imem_rdata = $urandom;
            chk("stall_valid", {31'd0, inst_valid}, 32'd1);
            chk("stall_inst", inst, iw);
            chk("stall_pc", pc_out, m_pc);
            chk("stall_retired", retired, m_retired);
        end
        exec_stall     = 1'b0;
        branch         = br;
        jr_target      = jr;
        bus.imem_ready = 1'b0;
        @(negedge clk);
        m_pc      = model_next(m_pc, iw, br, jr);
        m_retired = m_retired + 32'd1;
        chk("ret_count", retired, m_retired);
        chk("ret_valid", {31'd0, inst_valid}, 32'd0);
        chk("ret_pc", pc_out, m_pc);
        chk("ret_jmis", {31'd0, jr_misalign},
            {31'd0, (br == 2'b11) && (jr[1:0] != 2'b00)});
        o_addr    = bus.imem_addr;
        o_mis     = jr_misalign;
        branch    = 2'($urandom);
        jr_target = $urandom;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        logic        mis;
        logic [31:0] addrs[3];
        int          n;
        int          w;
        logic [31:0] jr;

        vecs[0] = '{32'h0000_0010, 32'h1000_FFFE, 2'b01, 32'h0,         32'h0000_000C, 1'b0};
        vecs[1] = '{32'h3000_0004, 32'h0800_0040, 2'b10, 32'h0,         32'h3000_0100, 1'b0};
        vecs[2] = '{32'h0000_0040, 32'h0000_0000, 2'b11, 32'h0000_0123, 32'h0000_0120, 1'b1};
        vecs[3] = '{32'hFFFF_FFFC, 32'h1234_5678, 2'b00, 32'h0,         32'h0000_0000, 1'b0};
        vecs[4] = '{32'h0000_0004, 32'h1000_8000, 2'b01, 32'h0,         32'hFFFE_0008, 1'b0};
        vecs[5] = '{32'h7FFF_FFF8, 32'h0000_7FFF, 2'b01, 32'h0,         32'h8001_FFF8, 1'b0};
        vecs[6] = '{32'hF000_0000, 32'h0BFF_FFFF, 2'b10, 32'h0,         32'hFFFF_FFFC, 1'b0};
        vecs[7] = '{32'h0000_0100, 32'h0000_0000, 2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 1'b1};

        rst_n          = 1'b1;
        branch         = 2'b00;
        jr_target      = 32'd0;
        exec_stall     = 1'b0;
        bus.imem_ready = 1'b0;
        bus.imem_rdata = 32'd0;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_req", {31'd0, bus.imem_req}, 32'd0);
        chk("rst_addr", bus.imem_addr, RESET_PC);
        chk("rst_valid", {31'd0, inst_valid}, 32'd0);
        chk("rst_inst", inst, 32'd0);
        chk("rst_retired", retired, 32'd0);
        chk("rst_ferr", {31'd0, fetch_err}, 32'd0);
        chk("rst_jmis", {31'd0, jr_misalign}, 32'd0);

        // Zero-wait memory, sequential flow.
        bus.imem_ready = 1'b1;
        rst_n = 1'b1;
        n = 0;
        w = 0;
        while (retired != 32'd3 && w < 20) begin
            @(negedge clk);
            w++;
            if (bus.imem_req && n < 3) begin
                addrs[n] = bus.imem_addr;
                n++;
            end
        end
        bus.imem_ready = 1'b0;
        chk("seq_retired", retired, 32'd3);
        chk("seq_nfetch", n, 3);
        chk("seq_addr0", addrs[0], 32'h0);
        chk("seq_addr1", addrs[1], 32'h4);
        chk("seq_addr2", addrs[2], 32'h8);
        m_pc      = 32'hC;
        m_retired = 32'd3;

        foreach (vecs[i]) begin
            do_instr(32'h0, 2'b11, vecs[i].pc, 0, 0, a, mis);
            chk("vec_setup", a, vecs[i].pc);
            do_instr(vecs[i].iw, vecs[i].br, vecs[i].jr,
                     $urandom_range(0, 2), $urandom_range(0, 3), a, mis);
            chk("vec_next", a, vecs[i].exp_next);
            chk("vec_mis", {31'd0, mis}, {31'd0, vecs[i].exp_mis});
        end

        // Fetch timeout: 16 waiting cycles, one cycle of dropped request, re-issue.
        bus.imem_ready = 1'b0;
        for (int k = 0; k < 20; k++) begin
            chk("to_req", {31'd0, bus.imem_req}, {31'd0, k != 16});
            chk("to_ferr", {31'd0, fetch_err}, {31'd0, k == 16});
            chk("to_addr", bus.imem_addr, m_pc);
            @(negedge clk);
        end
        do_instr($urandom, 2'b00, 32'd0, 0, 0, a, mis);

        // Ready arriving on the last timeout cycle is accepted.
        do_instr($urandom, 2'b00, 32'd0, 0, 15, a, mis);
        // Long stall.
        do_instr($urandom, 2'b01, 32'd0, 5, 1, a, mis);

        for (int i = 0; i < 40; i++) begin
            jr = $urandom;
            if ($urandom_range(0, 3) != 0) jr[1:0] = 2'b00;
            do_instr($urandom, 2'($urandom), jr, $urandom_range(0, 3), $urandom_range(0, 4), a, mis);
        end

        // Reset in the middle of a stalled instruction.
        w = 0;
        while (!bus.imem_req && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("mid_req", {31'd0, bus.imem_req}, 32'd1);
        bus.imem_ready = 1'b1;
        bus.imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.imem_ready = 1'b0;
        exec_stall = 1'b1;
        repeat (2) @(negedge clk);
        chk("mid_valid", {31'd0, inst_valid}, 32'd1);
        chk("mid_retired_before", retired, m_retired);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_addr", bus.imem_addr, RESET_PC);
        chk("mid_rst_retired", retired, 32'd0);
        chk("mid_rst_valid", {31'd0, inst_valid}, 32'd0);
        chk("mid_rst_req", {31'd0, bus.imem_req}, 32'd0);
        chk("mid_rst_inst", inst, 32'd0);
        @(negedge clk);
        rst_n      = 1'b1;
        exec_stall = 1'b0;
        m_pc       = RESET_PC;
        m_retired  = 32'd0;
        do_instr(32'h0800_0010, 2'b10, 32'd0, 0, 0, a, mis);
        chk("post_rst_next", a, 32'h0000_0040);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
